// File: rtl/fma_feeder_pkg.sv
// Shared definitions for the FMA feeder: register offsets,
// STATUS/CTRL bit positions and the decoded register select.
package fma_feeder_pkg;

    localparam logic [7:0] OFF_A    = 8'h00;
    localparam logic [7:0] OFF_B    = 8'h04;
    localparam logic [7:0] OFF_C    = 8'h08;
    localparam logic [7:0] OFF_RES  = 8'h0C;
    localparam logic [7:0] OFF_STAT = 8'h10;
    localparam logic [7:0] OFF_CTRL = 8'h14;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_UDF   = 4;
    localparam int ST_CNT   = 8;

    localparam int CTRL_SUB = 0;
    localparam int CTRL_CLR = 1;

    typedef enum logic [2:0] {
        R_NONE,
        R_A,
        R_B,
        R_C,
        R_RES,
        R_STAT,
        R_CTRL
    } reg_sel_e;

endpackage

// File: rtl/fp_fma_core.sv
// Single-precision fused multiply-add, fixed latency LAT.
// Ports: clk, rst_n, valid (operand strobe), a/b/c, op (1 = a*b-c), result.
module fp_fma_core #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic        op,
    output logic [31:0] result
);

    // Round-to-nearest-even, subnormals flushed to zero,
    // inf/NaN operands collapse to the canonical quiet NaN.
    function automatic logic [31:0] fma32(
        input logic [31:0] fa,
        input logic [31:0] fb,
        input logic [31:0] fc,
        input logic        fop
    );
        logic               sp, sc, sb, ss, sr;
        logic               pz, cz, p_big, stk, grd, rnd;
        logic        [23:0] ma, mb, mc;
        logic        [47:0] mp;
        logic signed [10:0] ep, ec, emax;
        logic        [10:0] diff;
        logic        [73:0] pw, cw, big, sml, lost;
        logic        [74:0] sum, nrm;
        logic        [24:0] man;
        logic        [22:0] frac;
        int                 lead, e;

        if (fa[30:23] == 8'hFF || fb[30:23] == 8'hFF ||
            fc[30:23] == 8'hFF)
            return 32'h7FC00000;

        ma = (fa[30:23] != 8'd0) ? {1'b1, fa[22:0]} : 24'd0;
        mb = (fb[30:23] != 8'd0) ? {1'b1, fb[22:0]} : 24'd0;
        mc = (fc[30:23] != 8'd0) ? {1'b1, fc[22:0]} : 24'd0;
        sp = fa[31] ^ fb[31];
        sc = fc[31] ^ fop;
        mp = ma * mb;
        pz = (mp == 48'd0);
        cz = (mc == 24'd0);

        if (pz && cz)
            return {sp & sc, 31'd0};

        // Both terms as fixed point with 72 fraction bits
        ep = 11'(fa[30:23]) + 11'(fb[30:23]) - 11'd127;
        ec = 11'(fc[30:23]);
        pw = {mp, 26'd0};
        cw = {1'b0, mc, 49'd0};

        p_big = cz || (!pz && (ep >= ec));
        emax  = p_big ? ep : ec;
        diff  = p_big ? 11'(ep - ec) : 11'(ec - ep);
        big   = p_big ? pw : cw;
        sml   = p_big ? cw : pw;
        sb    = p_big ? sp : sc;
        ss    = p_big ? sc : sp;

        // Align the smaller term; shifted-out bits jam into bit 0
        if (diff >= 11'd74) begin
            stk = |sml;
            sml = '0;
        end else begin
            lost = sml & ~({74{1'b1}} << diff);
            stk  = |lost;
            sml  = sml >> diff;
        end
        sml[0] = sml[0] | stk;

        if (sb == ss) begin
            sum = {1'b0, big} + {1'b0, sml};
            sr  = sb;
        end else if (big >= sml) begin
            sum = {1'b0, big - sml};
            sr  = sb;
        end else begin
            sum = {1'b0, sml - big};
            sr  = ss;
        end

        if (sum == 75'd0)
            return 32'd0;

        lead = 0;
        for (int i = 0; i < 75; i++)
            if (sum[i]) lead = i;

        e    = int'(emax) + lead - 72;
        nrm  = sum << (74 - lead);
        grd  = nrm[50];
        rnd  = grd & ((|nrm[49:0]) | nrm[51]);
        man  = {1'b0, nrm[74:51]} + 25'(rnd);
        frac = man[22:0];
        if (man[24]) begin
            e    = e + 1;
            frac = man[23:1];
        end

        if (e >= 255)
            return {sr, 8'hFF, 23'd0};
        if (e <= 0)
            return {sr, 31'd0};
        return {sr, 8'(e), frac};
    endfunction

    logic [31:0] pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++)
                pipe[i] <= '0;
        end else begin
            if (valid)
                pipe[0] <= fma32(a, b, c, op);
            for (int i = 1; i < LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];

endmodule

// File: rtl/fma_feeder_q.sv
// Bus-mapped feeder for an FMA core with a queued result FIFO.
// Ports: clk_i, rst_ni, en_i/we_i/addr_i/data_i (access), ready_o/data_o (response).
module fma_feeder_q
    import fma_feeder_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] BASE  = 32'hC4200000,
    parameter int              DEPTH = 4,
    parameter int              LAT   = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic            ready_o,
    output logic [XLEN-1:0] data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    reg_sel_e        sel;
    logic [XLEN-1:0] off;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] status;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            sub_q;
    logic            ovf;
    logic            udf;

    logic            iss_v;
    logic            iss_op;
    logic [31:0]     iss_a;
    logic [31:0]     iss_b;
    logic [31:0]     iss_c;
    logic [31:0]     core_res;
    logic [LAT-1:0]  infl;

    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;

    logic            rd;
    logic            wr;
    logic            push;
    logic            pop;
    logic            credit;
    logic            issue;
    logic [7:0]      n_infl;
    logic [15:0]     used;

    always_comb begin
        off = addr_i - BASE;
        unique case (1'b1)
            off == XLEN'(OFF_A):    sel = R_A;
            off == XLEN'(OFF_B):    sel = R_B;
            off == XLEN'(OFF_C):    sel = R_C;
            off == XLEN'(OFF_RES):  sel = R_RES;
            off == XLEN'(OFF_STAT): sel = R_STAT;
            off == XLEN'(OFF_CTRL): sel = R_CTRL;
            default:                sel = R_NONE;
        endcase
    end

    assign rd   = en_i & ~we_i;
    assign wr   = en_i & we_i;
    assign push = infl[LAT-1];
    assign pop  = rd && (sel == R_RES) && (count != '0);

    // The issue register counts as in flight as well
    always_comb begin
        n_infl = 8'(iss_v);
        for (int i = 0; i < LAT; i++)
            n_infl = n_infl + 8'(infl[i]);
    end

    // A same-cycle pop frees a slot for this issue
    assign used   = 16'(n_infl) + 16'(count) - 16'(pop);
    assign credit = used < 16'(DEPTH);
    assign issue  = wr && (sel == R_C) && credit;

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = (count == '0);
        status[ST_FULL]  = (count == CW'(DEPTH));
        status[ST_BUSY]  = (n_infl != 8'd0);
        status[ST_OVF]   = ovf;
        status[ST_UDF]   = udf;
        status[ST_CNT +: 8] = 8'(count);
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            R_A:     rdata = a_q;
            R_B:     rdata = b_q;
            R_RES:   if (count != '0) rdata = XLEN'(mem[rptr]);
            R_STAT:  rdata = status;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_o <= 1'b0;
            data_o  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            ready_o <= en_i;
            data_o  <= rd ? rdata : '0;
            if (wr && sel == R_A)
                a_q <= data_i;
            if (wr && sel == R_B)
                b_q <= data_i;
            if (wr && sel == R_CTRL) begin
                sub_q <= data_i[CTRL_SUB];
                if (data_i[CTRL_CLR]) begin
                    ovf <= 1'b0;
                    udf <= 1'b0;
                end
            end
            if (wr && sel == R_C && !credit)
                ovf <= 1'b1;
            if (rd && sel == R_RES && count == '0)
                udf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_v  <= 1'b0;
            iss_op <= 1'b0;
            iss_a  <= '0;
            iss_b  <= '0;
            iss_c  <= '0;
            infl   <= '0;
        end else begin
            iss_v <= issue;
            if (issue) begin
                iss_a  <= a_q[31:0];
                iss_b  <= b_q[31:0];
                iss_c  <= data_i[31:0];
                iss_op <= sub_q;
            end
            infl[0] <= iss_v;
            for (int i = 1; i < LAT; i++)
                infl[i] <= infl[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wptr] <= core_res;
    end

    fp_fma_core #(
        .LAT (LAT)
    ) u_core (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .valid  (iss_v),
        .a      (iss_a),
        .b      (iss_b),
        .c      (iss_c),
        .op     (iss_op),
        .result (core_res)
    );

endmodule

// File: tb/tb_fma_feeder_q.sv
// Scoreboard bench for fma_feeder_q: every access queues its
// expected response, a negedge monitor checks each ready pulse.
module tb_fma_feeder_q;

    localparam logic [31:0] BASE = 32'hC4200000;
    localparam int          LAT  = 3;

    localparam logic [7:0] A    = 8'h00;
    localparam logic [7:0] B    = 8'h04;
    localparam logic [7:0] C    = 8'h08;
    localparam logic [7:0] RES  = 8'h0C;
    localparam logic [7:0] STAT = 8'h10;
    localparam logic [7:0] CTRL = 8'h14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] rdat;

    int nvec = 0;
    int nmis = 0;

    logic [31:0] expq [$];
    string       nmq  [$];

    fma_feeder_q #(
        .XLEN  (32),
        .BASE  (BASE),
        .DEPTH (4),
        .LAT   (LAT)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .we_i    (we),
        .addr_i  (addr),
        .data_i  (wdata),
        .ready_o (rdy),
        .data_o  (rdat)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [7:0] o,
                       input logic [31:0] d, input logic [31:0] x,
                       input string nm);
        en    = 1'b1;
        we    = w;
        addr  = BASE + 32'(o);
        wdata = d;
        expq.push_back(x);
        nmq.push_back(nm);
        @(posedge clk);
        #1;
        en = 1'b0;
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (expq.size() == 0) begin
                check("stray_ready", {31'd0, rdy}, 32'd0);
            end else begin
                logic [31:0] x;
                string       nm;
                x  = expq.pop_front();
                nm = nmq.pop_front();
                check(nm, rdat, x);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, rdy}, 32'd0);
        check("rst_data", rdat, 32'd0);
        rst_n = 1'b1;
        idle(1);

        bus(0, STAT, 0, 32'h1, "stat_reset");

        // 2*3+1
        bus(1, A, 32'h40000000, 0, "wr_a");
        bus(1, B, 32'h40400000, 0, "wr_b");
        bus(0, A, 0, 32'h40000000, "rd_a");
        bus(0, B, 0, 32'h40400000, "rd_b");
        bus(1, C, 32'h3F800000, 0, "wr_c");
        bus(0, STAT, 0, 32'h5, "stat_busy");
        idle(3);
        bus(0, RES, 0, 32'h40E00000, "res_fma");
        bus(0, STAT, 0, 32'h1, "stat_empty");

        // 2*3-1
        bus(1, CTRL, 32'h1, 0, "ctrl_sub");
        bus(1, C, 32'h3F800000, 0, "wr_c_sub");
        idle(5);
        bus(0, RES, 0, 32'h40A00000, "res_fms");
        bus(1, CTRL, 32'h0, 0, "ctrl_add");

        // five back-to-back issues, fifth dropped
        bus(1, C, 32'h3F800000, 0, "c1");
        bus(1, C, 32'h40000000, 0, "c2");
        bus(1, C, 32'h40400000, 0, "c3");
        bus(1, C, 32'h40800000, 0, "c4");
        bus(1, C, 32'h40A00000, 0, "c5");
        idle(6);
        bus(0, STAT, 0, 32'h40A, "stat_full_ovf");
        bus(1, CTRL, 32'h2, 0, "ctrl_clr");
        bus(0, STAT, 0, 32'h402, "stat_ovf_clr");

        // pop, refill, then pop in the push cycle (pointer wraps)
        bus(0, RES, 0, 32'h40E00000, "q0_7");
        bus(1, C, 32'h40C00000, 0, "c6");
        idle(LAT);
        bus(0, RES, 0, 32'h41000000, "q1_8_pushpop");
        bus(0, STAT, 0, 32'h300, "stat_cnt3");
        bus(0, RES, 0, 32'h41100000, "q2_9");
        bus(0, RES, 0, 32'h41200000, "q3_10");
        bus(0, RES, 0, 32'h41400000, "q4_12_wrap");
        bus(0, STAT, 0, 32'h1, "stat_drained");

        // underflow
        bus(0, RES, 0, 32'h0, "res_empty");
        idle(1);
        check("ready_single", {31'd0, rdy}, 32'd0);
        bus(0, STAT, 0, 32'h11, "stat_udf");
        bus(1, CTRL, 32'h2, 0, "ctrl_clr2");
        bus(0, STAT, 0, 32'h1, "stat_udf_clr");

        // unmapped and write-only locations
        bus(1, 8'h18, 32'hDEADBEEF, 0, "wr_unmapped");
        bus(0, 8'h18, 0, 32'h0, "rd_unmapped");
        bus(0, C, 0, 32'h0, "rd_c_wo");
        bus(0, CTRL, 0, 32'h0, "rd_ctrl_wo");
        bus(0, A, 0, 32'h40000000, "a_kept");
        bus(0, B, 0, 32'h40400000, "b_kept");

        // reset with an operation in flight
        bus(1, C, 32'h3F800000, 0, "c_then_rst");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst2_ready", {31'd0, rdy}, 32'd0);
        check("rst2_data", rdat, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
        bus(0, STAT, 0, 32'h1, "stat_after_rst");
        bus(0, RES, 0, 32'h0, "res_after_rst");
        bus(0, A, 0, 32'h0, "a_after_rst");

        idle(3);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule
